// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, immediate-format selects and the
// canonical NOP, plus the decode-stage action encoding.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_U    = 3'd4,
    IMM_NONE = 3'd5
  } imm_sel_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_FREEZE,
    ACT_REDIRECT,
    ACT_LU_STALL
  } action_e;

endpackage

// File: rtl/instr_class.sv
// Opcode classifier: immediate format plus register-usage flags. Shared with
// the immediate generator's select logic.
module instr_class
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  imm_sel_e fmt;

  always_comb begin
    fmt       = IMM_NONE;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    unique case (opcode)
      OP_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_OPIMM, OP_JALR: begin
        fmt       = IMM_I;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        fmt       = IMM_I;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_STORE: begin
        fmt      = IMM_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        fmt      = IMM_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        fmt       = IMM_J;
        writes_rd = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        fmt       = IMM_U;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_sel = fmt;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer: owns IF/ID, detects load-use hazards, squashes the
// wrong-path instruction on redirect, freezes on memory stall, counts events.
module id_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             ex_taken,
  input  logic             mem_stall,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic [2:0]       imm_sel,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic       lu;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  action_e    act;

  instr_class u_class (
    .opcode    (id_instr[6:0]),
    .imm_sel   (imm_sel),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  always_comb begin
    lu = id_valid & ex_is_load & (ex_rd != 5'd0) &
         ((uses_rs1 & (id_instr[19:15] == ex_rd)) |
          (uses_rs2 & (id_instr[24:20] == ex_rd)));
  end

  always_comb begin
    act = ACT_RUN;
    if (mem_stall)     act = ACT_FREEZE;
    else if (ex_taken) act = ACT_REDIRECT;
    else if (lu)       act = ACT_LU_STALL;
  end

  // Outputs gated by rst_n so a reset mid-stall or mid-redirect drops them at once.
  always_comb begin
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    id_bubble = 1'b0;
    if (rst_n) begin
      unique case (act)
        ACT_RUN:      pc_we = 1'b1;
        ACT_REDIRECT: begin
          pc_we     = 1'b1;
          pc_sel    = 1'b1;
          id_bubble = 1'b1;
        end
        ACT_LU_STALL: id_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr   <= NOP;
      id_pc      <= '0;
      id_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_is_load <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      unique case (act)
        ACT_FREEZE: ;
        ACT_REDIRECT: begin
          id_instr   <= NOP;
          id_valid   <= 1'b0;
          ex_rd      <= '0;
          ex_is_load <= 1'b0;
          if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
        ACT_LU_STALL: begin
          ex_rd      <= '0;
          ex_is_load <= 1'b0;
          if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
        default: begin
          id_instr   <= if_instr;
          id_pc      <= if_pc;
          id_valid   <= 1'b1;
          ex_rd      <= (id_valid & writes_rd) ? id_instr[11:7] : '0;
          ex_is_load <= id_valid & is_load;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl (CNT_W=4) against a format-level
// reference model of the decode stage.
module tb_id_hazard_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned SAT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_instr, if_pc;
  logic        ex_taken, mem_stall;
  logic        pc_we, pc_sel, id_valid, id_bubble;
  logic [31:0] id_instr, id_pc;
  logic [2:0]  imm_sel;
  logic [3:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_instr, m_pc;
  bit          m_valid, m_exld;
  logic [4:0]  m_exrd;
  int unsigned m_stall, m_flush, m_stall_raw;

  id_hazard_ctrl #(.CNT_W(4), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc),
    .ex_taken(ex_taken), .mem_stall(mem_stall), .pc_we(pc_we), .pc_sel(pc_sel),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .imm_sel(imm_sel),
    .id_bubble(id_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // 0=R 1=I 2=S 3=B 4=J 5=U 6=other
  function automatic int fmt_of(input logic [6:0] op);
    case (op)
      7'b0110011:                         return 0;
      7'b0010011, 7'b0000011, 7'b1100111: return 1;
      7'b0100011:                         return 2;
      7'b1100011:                         return 3;
      7'b1101111:                         return 4;
      7'b0110111, 7'b0010111:             return 5;
      default:                            return 6;
    endcase
  endfunction

  function automatic logic [2:0] m_imm();
    int f = fmt_of(m_instr[6:0]);
    return (f == 0 || f == 6) ? 3'd5 : 3'(f - 1);
  endfunction

  function automatic bit m_lu();
    int f = fmt_of(m_instr[6:0]);
    bit u1 = (f <= 3);
    bit u2 = (f == 0 || f == 2 || f == 3);
    return m_valid && m_exld && m_exrd != 0 &&
           ((u1 && m_instr[19:15] == m_exrd) || (u2 && m_instr[24:20] == m_exrd));
  endfunction

  function automatic bit m_pc_we();
    return !mem_stall && (ex_taken || !m_lu());
  endfunction
  function automatic bit m_pc_sel();
    return !mem_stall && ex_taken;
  endfunction
  function automatic bit m_bubble();
    return !mem_stall && (ex_taken || m_lu());
  endfunction

  task automatic model_reset();
    m_instr = NOP; m_pc = 0; m_valid = 0; m_exrd = 0; m_exld = 0;
    m_stall = 0; m_flush = 0; m_stall_raw = 0;
  endtask

  task automatic model_step();
    int f = fmt_of(m_instr[6:0]);
    if (mem_stall) begin
    end else if (ex_taken) begin
      m_instr = NOP; m_valid = 0; m_exrd = 0; m_exld = 0;
      if (m_flush < SAT) m_flush++;
    end else if (m_lu()) begin
      m_exrd = 0; m_exld = 0; m_stall_raw++;
      if (m_stall < SAT) m_stall++;
    end else begin
      m_exrd  = (m_valid && (f == 0 || f == 1 || f == 4 || f == 5)) ? m_instr[11:7] : 5'd0;
      m_exld  = m_valid && m_instr[6:0] == 7'b0000011;
      m_instr = if_instr; m_pc = if_pc; m_valid = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic tk, input logic ms);
    if_instr = ins; if_pc = pc; ex_taken = tk; mem_stall = ms;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(NOP, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (id_instr !== NOP || id_valid !== 1'b0 || id_pc !== 32'h0 || stall_cnt !== 4'd0 ||
        flush_cnt !== 4'd0 || pc_we !== 1'b0 || pc_sel !== 1'b0 || id_bubble !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: instr=%h valid=%b pc=%h sc=%0d fc=%0d we=%b sel=%b bub=%b (want 00000013 0 0 0 0 0 0 0)",
               id_instr, id_valid, id_pc, stall_cnt, flush_cnt, pc_we, pc_sel, id_bubble);
    end
    tick(); #1 rst_n = 1'b1; model_reset();
    // reach a load-use stall, then reset in the middle of it
    drive(32'h0000A283, 32'h100, 0, 0); tick();
    drive(32'h00228333, 32'h104, 0, 0); tick();
    drive(NOP, 32'h108, 0, 0);
    @(negedge clk);
    checks++;
    if (id_bubble !== 1'b1) begin
      errors++; $display("FAIL reset_pre_stall: id_bubble=%b want 1", id_bubble);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pc_we !== 1'b0 || id_bubble !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: we=%b bub=%b valid=%b instr=%h sc=%0d (want 0 0 0 00000013 0)",
               pc_we, id_bubble, id_valid, id_instr, stall_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; model_reset();
    @(negedge clk);
    checks++;
    if (id_bubble !== 1'b0 || pc_we !== 1'b1) begin
      errors++; $display("FAIL reset_release: bub=%b we=%b want 0 1", id_bubble, pc_we);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(32'h0000A283, 32'h100, 0, 0); tick();
    drive(32'h00228333, 32'h104, 0, 0);
    @(negedge clk);
    checks++;
    if (id_bubble !== 1'b0) begin errors++; $display("FAIL lu_before: bub=%b want 0", id_bubble); end
    tick();
    drive(NOP, 32'h108, 0, 0);
    @(negedge clk);
    checks++;
    if (id_bubble !== 1'b1 || pc_we !== 1'b0 || imm_sel !== 3'd5) begin
      errors++; $display("FAIL lu_stall: bub=%b we=%b imm=%0d want 1 0 5", id_bubble, pc_we, imm_sel);
    end
    tick();
    @(negedge clk);
    checks++;
    if (id_bubble !== 1'b0 || pc_we !== 1'b1 || stall_cnt !== 4'd1 || id_instr !== 32'h00228333) begin
      errors++; $display("FAIL lu_after: bub=%b we=%b sc=%0d instr=%h want 0 1 1 00228333",
                         id_bubble, pc_we, stall_cnt, id_instr);
    end
    tick();
  endtask

  task automatic test_x0_load();
    do_reset();
    drive(32'h0000A003, 32'h100, 0, 0); tick();
    drive(32'h00200333, 32'h104, 0, 0); tick();
    drive(NOP, 32'h108, 0, 0);
    @(negedge clk);
    checks++;
    if (id_bubble !== 1'b0 || pc_we !== 1'b1) begin
      errors++; $display("FAIL x0_no_stall: bub=%b we=%b want 0 1", id_bubble, pc_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL x0_cnt: sc=%0d want 0", stall_cnt); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    drive(32'h00100093, 32'h200, 0, 0); tick();
    drive(NOP, 32'h204, 1, 0);
    @(negedge clk);
    checks++;
    if (pc_sel !== 1'b1 || id_bubble !== 1'b1 || pc_we !== 1'b1) begin
      errors++; $display("FAIL redirect_out: sel=%b bub=%b we=%b want 1 1 1", pc_sel, id_bubble, pc_we);
    end
    tick();
    drive(NOP, 32'h300, 0, 0);
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || flush_cnt !== 4'd1) begin
      errors++; $display("FAIL redirect_squash: valid=%b instr=%h fc=%0d want 0 00000013 1",
                         id_valid, id_instr, flush_cnt);
    end
    tick();
    drive(32'h0000A283, 32'h300, 0, 0); tick();
    drive(32'h00228333, 32'h304, 0, 0); tick();
    drive(NOP, 32'h308, 1, 0);
    @(negedge clk);
    checks++;
    if (pc_sel !== 1'b1 || id_bubble !== 1'b1 || pc_we !== 1'b1) begin
      errors++; $display("FAIL redirect_over_lu: sel=%b bub=%b we=%b want 1 1 1", pc_sel, id_bubble, pc_we);
    end
    tick();
    drive(NOP, 32'h400, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd2 || id_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_over_lu_cnt: sc=%0d fc=%0d valid=%b want 0 2 0",
                         stall_cnt, flush_cnt, id_valid);
    end
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    drive(32'h0000A283, 32'h100, 0, 0); tick();
    drive(32'h00228333, 32'h104, 0, 0); tick();
    drive(NOP, 32'h108, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pc_we !== 1'b0 || id_bubble !== 1'b0 || pc_sel !== 1'b0 || id_instr !== 32'h00228333 ||
          id_pc !== 32'h104 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
        errors++; $display("FAIL freeze_hold[%0d]: we=%b bub=%b sel=%b instr=%h pc=%h sc=%0d fc=%0d",
                           i, pc_we, id_bubble, pc_sel, id_instr, id_pc, stall_cnt, flush_cnt);
      end
      tick();
    end
    drive(NOP, 32'h108, 1, 0);
    @(negedge clk);
    checks++;
    if (pc_sel !== 1'b1 || id_bubble !== 1'b1) begin
      errors++; $display("FAIL freeze_release: sel=%b bub=%b want 1 1", pc_sel, id_bubble);
    end
    tick();
    drive(NOP, 32'h500, 0, 0);
    @(negedge clk);
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL freeze_cnt: fc=%0d sc=%0d valid=%b want 1 0 0", flush_cnt, stall_cnt, id_valid);
    end
    tick();
  endtask

  task automatic test_imm();
    logic [31:0] ins [7] = '{32'h0062A223, 32'h008000EF, 32'h123452B7, 32'h00228333,
                             32'h00100093, 32'h00000063, 32'h00000297};
    logic [2:0]  exp [7] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd0, 3'd2, 3'd4};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(ins[i], 32'(i * 4), 0, 0); tick();
      @(negedge clk);
      checks++;
      if (imm_sel !== exp[i] || id_instr !== ins[i]) begin
        errors++; $display("FAIL imm_sel[%0d]: instr=%h imm=%0d want %h %0d", i, id_instr, imm_sel, ins[i], exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    int idx = 0;
    int cyc = 0;
    do_reset();
    while (m_stall_raw < 20 && cyc < 300) begin
      drive((idx % 2 == 0) ? 32'h0000A283 : 32'h00228333, 32'(idx * 4), 0, 0);
      @(negedge clk);
      checks++;
      if (id_bubble !== m_bubble() || pc_we !== m_pc_we()) begin
        errors++; $display("FAIL sat_cycle[%0d]: bub=%b we=%b want %b %b", cyc, id_bubble, pc_we, m_bubble(), m_pc_we());
      end
      if (m_pc_we()) idx++;
      tick();
      cyc++;
    end
    checks++;
    if (m_stall_raw < 20) begin
      errors++; $display("FAIL sat_budget: only %0d stalls in %0d cycles, want 20", m_stall_raw, cyc);
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: sc=%0d want 15", stall_cnt); end
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd  = 5'($urandom_range(0, 3));
    logic [4:0] rs1 = 5'($urandom_range(0, 3));
    logic [4:0] rs2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 6))
      0, 1:    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
      2:       return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      3:       return {7'h00, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
      4:       return {7'h00, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
      5:       return {20'($urandom), rd, 7'b0110111};
      default: return {25'($urandom), 7'b1110011};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] ins = rand_instr();
    logic [31:0] pc  = 32'h1000;
    logic        tk  = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!tk) tk = ($urandom_range(0, 99) < 12);
      drive(ins, pc, tk, $urandom_range(0, 99) < 20);
      @(negedge clk);
      checks++;
      if (id_instr !== m_instr || id_pc !== m_pc || id_valid !== m_valid || imm_sel !== m_imm() ||
          pc_we !== m_pc_we() || pc_sel !== m_pc_sel() || id_bubble !== m_bubble() ||
          stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
        errors++;
        $display("FAIL random[%0d]: instr=%h pc=%h v=%b imm=%0d we=%b sel=%b bub=%b sc=%0d fc=%0d want %h %h %b %0d %b %b %b %0d %0d",
                 c, id_instr, id_pc, id_valid, imm_sel, pc_we, pc_sel, id_bubble, stall_cnt, flush_cnt,
                 m_instr, m_pc, m_valid, m_imm(), m_pc_we(), m_pc_sel(), m_bubble(), m_stall, m_flush);
      end
      if (m_pc_we()) begin
        pc  = m_pc_sel() ? pc + 32'h100 : pc + 4;
        ins = rand_instr();
      end
      if (m_pc_sel()) tk = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NOP, 0, 0, 0);
    model_reset();
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect();
    test_freeze();
    test_imm();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Decode-stage sequencer for the five-stage RV32I pipeline. It owns the IF/ID pipeline register and classifies the decoded instruction into an immediate-format select for the immediate generator. It detects load-use hazards and inserts a bubble, and squashes the wrong-path instruction on a taken branch or jump. It also freezes the front end while data memory is busy and keeps saturating stall and flush counters.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
NOP, 32'h00000013, instruction value loaded into IF/ID on reset and on flush (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
if_instr  in  32  instruction fetched this cycle
if_pc  in  32  PC of if_instr
ex_taken  in  1  branch/jump resolved taken in EX; held high by its source until accepted
mem_stall  in  1  data memory busy; whole pipeline frozen
pc_we  out  1  PC register write enable
pc_sel  out  1  1 = PC takes the EX target, 0 = PC+4
id_instr  out  32  IF/ID instruction register
id_pc  out  32  IF/ID PC register
id_valid  out  1  IF/ID holds a live instruction
imm_sel  out  3  immediate format of id_instr: I=0, S=1, B=2, J=3, U=4, NONE=5
id_bubble  out  1  ID/EX must load NOP this cycle
stall_cnt  out  CNT_W  count of load-use bubbles, saturating
flush_cnt  out  CNT_W  count of accepted redirects, saturating

Behaviour:
- Reset (async, rst_n=0):
  - id_instr=NOP, id_pc=0, id_valid=0.
  - Tracker ex_rd=0, ex_is_load=0.
  - stall_cnt=0, flush_cnt=0.
  - While rst_n=0, combinational outputs are forced: pc_we=0, pc_sel=0, id_bubble=0.
- Classification (combinational, from id_instr[6:0]):
  - imm_sel I: 0010011, 0000011, 1100111.
  - imm_sel S: 0100011. B: 1100011. J: 1101111. U: 0110111, 0010111.
  - imm_sel NONE: everything else, including R-type 0110011.
  - uses_rs1: R, I, S, B. uses_rs2: R, S, B.
  - writes_rd: R, I, J, U.
  - is_load: 0000011.
- Load-use hazard (lu): id_valid & ex_is_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- Cycle actions are evaluated in priority order: mem_stall, then ex_taken, then lu, then normal.
  - FREEZE (mem_stall=1):
    - pc_we=0, id_bubble=0, pc_sel=0.
    - IF/ID, tracker and counters hold.
    - A pending ex_taken is not accepted.
  - REDIRECT (ex_taken=1):
    - pc_we=1, pc_sel=1, id_bubble=1.
    - Next cycle: id_instr=NOP, id_valid=0; tracker clears to 0/0; flush_cnt+1.
    - Load-use is ignored because the ID instruction is wrong-path.
  - LU_STALL (lu=1):
    - pc_we=0, id_bubble=1.
    - IF/ID holds; tracker clears to 0/0; stall_cnt+1.
    - The hazard therefore lasts exactly one cycle per load.
  - RUN:
    - pc_we=1, pc_sel=0, id_bubble=0.
    - IF/ID <= {if_instr, if_pc}, id_valid <= 1.
    - Tracker: ex_rd <= (id_valid & writes_rd) ? rd : 0; ex_is_load <= id_valid & is_load.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall or mid-redirect aborts the action immediately; there is no residual bubble after reset release.
- Latency: fetch to ID is 1 cycle; hazard and redirect outputs are same-cycle combinational.
- No combinational path from if_instr to any output.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC);
  - imm_sel encodings IMM_I..IMM_NONE;
  - the NOP constant.
- One combinational sub-module, instr_class, maps an instruction to {imm_sel, uses_rs1, uses_rs2, writes_rd, is_load}. It is reused by the immediate generator's select logic.

Test Plan:
- rst_n low for 2 cycles, then asserted again mid-LU_STALL -> id_instr=0x00000013, id_valid=0, counters 0, pc_we=0 while in reset; no bubble after release.
- Fetch lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333) -> with add in ID: id_bubble=1, pc_we=0 for exactly 1 cycle; next cycle id_bubble=0, stall_cnt=1.
- lw x0,0(x1) (0x0000A003), then add x6,x0,x2 (0x00200333) -> no stall, stall_cnt=0.
- ex_taken=1 for 1 cycle with a valid id_instr -> pc_sel=1, id_bubble=1; next cycle id_valid=0, id_instr=NOP, flush_cnt=1; ex_taken with lu both high -> redirect wins, stall_cnt unchanged.
- mem_stall=1 for 3 cycles during a pending load-use and ex_taken -> all state held, pc_we=0, id_bubble=0; after release, redirect taken first, then counters = flush 1 / stall 0.
- imm_sel: sw 0x0062A223 gives 1, jal 0x008000EF gives 3, lui 0x123452B7 gives 4, add gives 5. With CNT_W=4, 20 load-use stalls give stall_cnt=15.
